// File: rtl/lcd_pkg.sv
// Shared LCD-subsystem constants: ROM geometry and requester indices.
package lcd_pkg;

  localparam int unsigned ROM_ADDR_WIDTH = 17;
  localparam int unsigned ROM_DATA_WIDTH = 16;

  // Requester slots on the sprite/background ROM arbiter.
  localparam int unsigned REQ_LCD    = 0;
  localparam int unsigned REQ_SPRITE = 1;
  localparam int unsigned REQ_TILE   = 2;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot selector: first eligible bit at or above ptr_i, else wrap to
// the lowest eligible bit below it.
module rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    vec_i,
  input  logic [N-1:0]    mask_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    pick_o
);

  logic [N-1:0] elig;
  logic         found;

  // Two passes: upper segment [ptr, N) first, then the wrapped segment [0, ptr).
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    elig   = vec_i & mask_i;
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i] && (i >= int'(ptr_i))) begin
        pick_o[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i]) begin
        pick_o[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Arbiter sharing one single-port synchronous ROM among several LCD-side readers.
// Requester 0 (pixel fetcher) has fixed priority; the rest share leftover slots round-robin.
// Two-stage pipeline: grant -> rom_addr register -> ROM data register -> rd_valid.
// Optional starvation guard for requesters 1..NUM_REQ-1: define ROM_ARB_ANTISTARVE_EN.
module rom_read_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data,
  output logic                          busy
);

  localparam int unsigned IdW = $clog2(NUM_REQ);
  // Round-robin pool excludes the priority requester.
  localparam logic [NUM_REQ-1:0] RrMask = {{(NUM_REQ - 1){1'b1}}, 1'b0};

  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [IdW-1:0]        s1_id_q, s1_id_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [IdW-1:0]        s2_id_q, s2_id_d;

  logic [NUM_REQ-1:0]    rr_gnt;
  logic                  others_pend;
  logic                  grant_low;
  logic                  starve_override;
  logic [IdW-1:0]        gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;

  rr_pick #(
    .N    (NUM_REQ),
    .PtrW (IdW)
  ) u_rr_pick (
    .vec_i  (req),
    .mask_i (RrMask),
    .ptr_i  (rr_ptr_q),
    .pick_o (rr_gnt)
  );

  assign others_pend = |(req & RrMask);
  assign grant_low   = |(gnt & RrMask);

`ifdef ROM_ARB_ANTISTARVE_EN
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  // Only override priority while someone in the round-robin pool is actually waiting.
  assign starve_override = others_pend && (wait_cnt_q == WaitW'(MAX_WAIT));

  // Count cycles the round-robin pool is pending without being served.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!others_pend || grant_low) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign starve_override = 1'b0;

  logic unused_max_wait;
  assign unused_max_wait = ^32'(MAX_WAIT);
`endif

  // Grant: priority requester unless overridden, otherwise round-robin winner.
  always_comb begin
    gnt = '0;
    if (!rst_n) begin
      gnt = '0;
    end else if (req[REQ_LCD] && !starve_override) begin
      gnt[REQ_LCD] = 1'b1;
    end else begin
      gnt = rr_gnt;
    end
  end

  // Encode the granted index and pick its address slice.
  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = IdW'(i);
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Pipeline and round-robin pointer next state.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    s1_valid_d = |gnt;
    s1_id_d    = gnt_idx;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
    if (|gnt) begin
      rom_addr_d = sel_addr;
    end
    if (grant_low) begin
      rr_ptr_d = (gnt_idx == IdW'(NUM_REQ - 1)) ? IdW'(1) : gnt_idx + 1'b1;
    end
  end

  // State registers; reset discards any in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= IdW'(1);
      rom_addr_q <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
    end
  end

  // Tag the ROM output word with the requester that issued it two cycles ago.
  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_valid[i] = s2_valid_q && (s2_id_q == IdW'(i));
    end
  end

  assign rd_data  = rom_data;
  assign rom_addr = rom_addr_q;
  assign busy     = s1_valid_q | s2_valid_q;

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one single-port synchronous sprite/background ROM (registered output, 1-cycle read latency, `ADDR_WIDTH`=17, `DATA_WIDTH`=16) among several LCD-side readers.
- Requester 0 is the real-time LCD pixel fetcher and has fixed top priority. Requesters 1..NUM_REQ-1 (sprite and tile fetchers) share the leftover slots round-robin.
- Sits between the fetch engines and the ROM instance. It owns the ROM address register and tags each returned word to its requester.

Parameters:
- `ADDR_WIDTH`, 17, ROM word address width.
- `DATA_WIDTH`, 16, ROM word width (RGB565).
- `NUM_REQ`, 3, number of requesters (2..8); index 0 is priority.
- `MAX_WAIT`, 15, starvation threshold in cycles (used only with the optional feature).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  per-requester read request, level.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; slice i = `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `gnt`  out  NUM_REQ  one-hot or zero, combinational; the request is accepted this cycle.
- `rd_valid`  out  NUM_REQ  one-hot or zero, registered; `rd_data` belongs to this requester.
- `rd_data`  out  DATA_WIDTH  returned word (driven from `rom_data`).
- `rom_addr`  out  ADDR_WIDTH  registered address to ROM.
- `rom_data`  in  DATA_WIDTH  ROM registered output.
- `busy`  out  1  any read is in flight (either pipeline stage valid).

Behaviour:
- Reset (async, `rst_n`=0): `rom_addr`=0, `rd_valid`=0, `busy`=0, both pipeline stage valids=0, `rr_ptr`=1, `wait_cnt`=0. `gnt` is 0 while reset is asserted.
- Handshake: valid/ready style.
  - A transfer occurs in cycle t when `req[i]`&`gnt[i]`.
  - The requester holds `req`/`addr` stable until granted.
  - It may keep `req` high with a new address in t+1 for back-to-back reads.
  - Throughput is 1 read per cycle.
- Arbitration, evaluated every cycle:
  - If `req[0]`, then `gnt[0]`.
  - Else grant the first requesting index ≥`rr_ptr` scanning 1..NUM_REQ-1 with wrap (index 0 skipped).
  - On a grant to index k≥1: `rr_ptr` ← k+1, wrapping to 1 after NUM_REQ-1. A grant to 0 leaves `rr_ptr` unchanged.
- Pipeline:
  - Cycle t: grant. End of t: `rom_addr` ← selected addr; s1_valid ← 1; s1_id ← k.
  - End of t+1: ROM registers data; s2_valid ← s1_valid; s2_id ← s1_id.
  - Cycle t+2: `rd_valid[s2_id]`=s2_valid and `rd_data`=`rom_data`.
  - Fixed latency: grant to `rd_valid` = 2 cycles.
- Idle: no grant means `rom_addr` holds its last value and s1_valid ← 0; no spurious `rd_valid`.
- `busy` = s1_valid | s2_valid.
- Boundaries:
  - Simultaneous requests from all requesters: 0 wins.
  - `req` dropped before grant: no effect, and `rr_ptr` does not move.
  - `NUM_REQ`=2: requester 1 is served whenever `req[0]`=0.
  - Reset mid-read: in-flight words are discarded and no `rd_valid` is issued after release.
  - Requester 0 continuously requesting starves the others; this is permitted unless the optional feature is enabled.

Optional Feature:
- Macro `ROM_ARB_ANTISTARVE_EN`.
- Enabled:
  - `wait_cnt` (clog2(MAX_WAIT+1) bits) increments each cycle in which some `req[k≥1]` is high but not granted. It resets to 0 on any grant to k≥1 or when no `req[k≥1]` is pending.
  - When `wait_cnt`==`MAX_WAIT`, the next arbitration overrides `req[0]` and grants the round-robin winner among 1..NUM_REQ-1. `wait_cnt` then returns to 0.
- Disabled: strict priority for 0; `wait_cnt` absent.

Decomposition:
- Shared package/header `lcd_pkg`: `ROM_ADDR_WIDTH`=17, `ROM_DATA_WIDTH`=16, requester index constants (`REQ_LCD`=0, `REQ_SPRITE`=1, `REQ_TILE`=2).
- One natural sub-module: `rr_pick`, a combinational rotating-priority one-hot selector taking mask, pointer and vector.
- Pipeline, priority override and counters stay in the top.

Test Plan:
- Single read: `req[1]`=1, addr=0x00010 (ROM preloaded mem[0x10]=0xBEEF) → `gnt[1]` same cycle; 2 cycles later `rd_valid`=3'b010, `rd_data`=0xBEEF.
- Back-to-back: `req[0]` held 4 cycles, addr 0x100..0x103 → `gnt[0]` 4 consecutive cycles; `rd_valid[0]` 4 consecutive cycles with mem[0x100..0x103] in order.
- Round-robin: `req[1]` and `req[2]` held high, `req[0]`=0, 6 cycles → grants alternate 1,2,1,2,1,2, starting with 1 after reset.
- Priority: `req`=3'b111 for 3 cycles → `gnt`=3'b001 each cycle; drop `req[0]` → next grant to 1, then 2.
- Reset mid-flight: grant to 2 at t, assert `rst_n`=0 at t+1 → `rd_valid`=0 through t+3, `rom_addr`=0, `busy`=0.
- With `ROM_ARB_ANTISTARVE_EN`, `MAX_WAIT`=15: `req[0]` and `req[1]` continuously high → `gnt[1]` exactly once every 16 cycles, else `gnt[0]`. Without the macro: `gnt[1]` never asserts.
